// File: rtl/func4_pkg.sv
// Shared definitions for the func4 number classifier: the classification
// rules and the elaboration-time lookup table built from them.
package func4_pkg;

    // Widest input the table is sized for.
    localparam int MAX_WIDTH   = 8;
    localparam int MAX_ENTRIES = 1 << MAX_WIDTH;

    // One table entry: the two flags for a single input value.
    typedef struct packed {
        logic prime;
        logic div3;
    } class_t;

    // Whole table packed into one vector. Entry i occupies bits [2*i +: 2].
    typedef logic [2*MAX_ENTRIES-1:0] lut_vec_t;

    // Trial division is evaluated only at elaboration. Any composite value
    // below 256 has a factor no larger than 15, so that bound covers MAX_WIDTH.
    function automatic logic is_prime(input int n);
        logic result;
        result = (n >= 2);
        for (int k = 2; k <= 15; k++) begin
            if ((k < n) && ((n % k) == 0)) begin
                result = 1'b0;
            end
        end
        return result;
    endfunction

    // Zero counts as divisible by 3.
    function automatic logic is_div3(input int n);
        return ((n % 3) == 0);
    endfunction

    // Table of {prime, div3} for every value representable in 'width' bits.
    // Entries above 2**width - 1 are unreachable and left at zero.
    function automatic lut_vec_t build_lut(input int width);
        lut_vec_t table_v;
        class_t   entry;
        table_v = '0;
        for (int i = 0; i < MAX_ENTRIES; i++) begin
            if (i < (1 << width)) begin
                entry.prime       = is_prime(i);
                entry.div3        = is_div3(i);
                table_v[2*i +: 2] = entry;
            end
        end
        return table_v;
    endfunction

endpackage

// File: rtl/func4_lut.sv
// Combinational classifier: looks the input value up in a constant table
// built at elaboration, so no divider logic ever reaches the netlist.
module func4_lut
    import func4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a_i,
    output logic             prime_o,
    output logic             div3_o
);

    localparam lut_vec_t LUT   = build_lut(WIDTH);
    localparam int       IDX_W = $clog2(2 * MAX_ENTRIES);

    logic [IDX_W-1:0] bit_idx;
    class_t           entry;

    // Bit position of the entry for a_i (two bits per entry).
    assign bit_idx = IDX_W'({a_i, 1'b0});
    assign entry   = LUT[bit_idx +: 2];
    assign prime_o = entry.prime;
    assign div3_o  = entry.div3;

endmodule

// File: rtl/func4.sv
// Registered number classifier: flags whether the sampled value is prime
// and whether it is divisible by 3, one clock after sampling.
module func4
    import func4_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic             in_valid,
    output logic             p,
    output logic             d,
    output logic             out_valid
);

    logic prime_c;
    logic div3_c;
    logic p_q, p_d;
    logic d_q, d_d;
    logic out_valid_q, out_valid_d;

    func4_lut #(
        .WIDTH(WIDTH)
    ) u_lut (
        .a_i    (a),
        .prime_o(prime_c),
        .div3_o (div3_c)
    );

    // Next state: load new flags on a valid sample, otherwise hold them;
    // the valid flag simply follows in_valid.
    always_comb begin
        p_d         = p_q;
        d_d         = d_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            p_d = prime_c;
            d_d = div3_c;
        end
    end

    // Output registers, cleared immediately whenever rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q         <= 1'b0;
            d_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            p_q         <= p_d;
            d_q         <= d_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign p         = p_q;
    assign d         = d_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_func4.sv
// Self-checking bench for func4 at WIDTH=4 and WIDTH=5.
module tb_func4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = '0;
    logic       in_valid = 1'b0;
    logic       p, d, out_valid;

    logic [4:0] a5 = '0;
    logic       in_valid5 = 1'b0;
    logic       p5, d5, out_valid5;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    func4 #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .in_valid (in_valid),
        .p        (p),
        .d        (d),
        .out_valid(out_valid)
    );

    func4 #(.WIDTH(5)) dut5 (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a5),
        .in_valid (in_valid5),
        .p        (p5),
        .d        (d5),
        .out_valid(out_valid5)
    );

    // Reference rules, straight from the definitions.
    function automatic bit ref_prime(int n);
        if (n < 2) return 1'b0;
        for (int k = 2; k < n; k++) if ((n % k) == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit ref_div3(int n);
        return (n % 3) == 0;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom_range(0, 15));
            tick();
            n_cmp++;
            if ({p, d, out_valid} !== 3'b000) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d a=%0d got p=%b d=%b v=%b want p=0 d=0 v=0",
                         i, a, p, d, out_valid);
            end
        end
        rst_n = 1'b1;
        a     = 4'd3;
        tick();
        n_cmp++;
        if ({p, d, out_valid} !== 3'b111) begin
            n_err++;
            $display("FAIL reset_release a=3 got p=%b d=%b v=%b want p=1 d=1 v=1",
                     p, d, out_valid);
        end
        $display("test_reset: release a=3 -> p=%b d=%b v=%b", p, d, out_valid);
    endtask

    task automatic test_sweep;
        bit ep, ed;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            tick();
            ep = ref_prime(i);
            ed = ref_div3(i);
            n_cmp++;
            if ({p, d, out_valid} !== {ep, ed, 1'b1}) begin
                n_err++;
                $display("FAIL sweep a=%0d got p=%b d=%b v=%b want p=%b d=%b v=1",
                         i, p, d, out_valid, ep, ed);
            end
            $display("sweep a=%0d -> p=%b d=%b v=%b", i, p, d, out_valid);
        end
    endtask

    task automatic test_corners;
        int corner_a [5] = '{0, 1, 2, 9, 15};
        bit exp_p    [5] = '{0, 0, 1, 0, 0};
        bit exp_d    [5] = '{1, 0, 0, 1, 1};
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 4'(corner_a[i]);
            tick();
            n_cmp++;
            if ({p, d, out_valid} !== {exp_p[i], exp_d[i], 1'b1}) begin
                n_err++;
                $display("FAIL corner a=%0d got p=%b d=%b v=%b want p=%b d=%b v=1",
                         corner_a[i], p, d, out_valid, exp_p[i], exp_d[i]);
            end
            $display("corner a=%0d -> p=%b d=%b", corner_a[i], p, d);
        end
    endtask

    task automatic test_hold;
        in_valid = 1'b1;
        a        = 4'd13;
        tick();
        n_cmp++;
        if ({p, d, out_valid} !== 3'b101) begin
            n_err++;
            $display("FAIL hold_load a=13 got p=%b d=%b v=%b want p=1 d=0 v=1",
                     p, d, out_valid);
        end
        in_valid = 1'b0;
        a        = 4'd6;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({p, d, out_valid} !== 3'b100) begin
                n_err++;
                $display("FAIL hold_idle cyc=%0d got p=%b d=%b v=%b want p=1 d=0 v=0",
                         i, p, d, out_valid);
            end
        end
        $display("test_hold: idle with a=6 -> p=%b d=%b v=%b", p, d, out_valid);
    endtask

    task automatic test_async_reset;
        bit ep, ed;
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            tick();
            ep = ref_prime(i);
            ed = ref_div3(i);
            n_cmp++;
            if ({p, d, out_valid} !== {ep, ed, 1'b1}) begin
                n_err++;
                $display("FAIL async_sweep a=%0d got p=%b d=%b v=%b want p=%b d=%b v=1",
                         i, p, d, out_valid, ep, ed);
            end
            if (i == 7) begin
                // Pulse reset strictly between clock edges.
                #1 rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({p, d, out_valid} !== 3'b000) begin
                    n_err++;
                    $display("FAIL async_clear got p=%b d=%b v=%b want p=0 d=0 v=0",
                             p, d, out_valid);
                end
                $display("async reset pulse -> p=%b d=%b v=%b", p, d, out_valid);
                #1 rst_n = 1'b1;
            end
        end
    endtask

    task automatic test_random;
        bit exp_p = 1'b0, exp_d = 1'b0, exp_v;
        int val;
        bit vld;
        for (int i = 0; i < 200; i++) begin
            val = $urandom_range(0, 15);
            vld = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            a        = 4'(val);
            in_valid = vld;
            tick();
            if (vld) begin
                exp_p = ref_prime(val);
                exp_d = ref_div3(val);
            end
            exp_v = vld;
            n_cmp++;
            if ({p, d, out_valid} !== {exp_p, exp_d, exp_v}) begin
                n_err++;
                $display("FAIL random cyc=%0d a=%0d vld=%b got p=%b d=%b v=%b want p=%b d=%b v=%b",
                         i, val, vld, p, d, out_valid, exp_p, exp_d, exp_v);
            end
        end
        in_valid = 1'b0;
        $display("test_random: 200 cycles of random a/in_valid checked");
    endtask

    task automatic test_width5;
        int spot_a [3] = '{31, 27, 17};
        bit spot_p [3] = '{1, 0, 1};
        bit spot_d [3] = '{0, 1, 0};
        bit ep, ed;
        in_valid5 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a5 = 5'(spot_a[i]);
            tick();
            n_cmp++;
            if ({p5, d5, out_valid5} !== {spot_p[i], spot_d[i], 1'b1}) begin
                n_err++;
                $display("FAIL w5_spot a=%0d got p=%b d=%b v=%b want p=%b d=%b v=1",
                         spot_a[i], p5, d5, out_valid5, spot_p[i], spot_d[i]);
            end
            $display("w5 a=%0d -> p=%b d=%b", spot_a[i], p5, d5);
        end
        for (int i = 0; i < 32; i++) begin
            a5 = 5'(i);
            tick();
            ep = ref_prime(i);
            ed = ref_div3(i);
            n_cmp++;
            if ({p5, d5, out_valid5} !== {ep, ed, 1'b1}) begin
                n_err++;
                $display("FAIL w5_sweep a=%0d got p=%b d=%b v=%b want p=%b d=%b v=1",
                         i, p5, d5, out_valid5, ep, ed);
            end
        end
        in_valid5 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_corners();
        test_hold();
        test_async_reset();
        test_random();
        test_width5();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
